// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//
// Memory-side responder for the datapath's word-addressed load/store port.
// A request seen in IDLE is captured, held for LATENCY wait cycles, and then
// answered with a single-cycle Ready pulse. The storage is a cleared-on-reset
// register array of DEPTH words.
//
// Parameters:
//   NBITS   - data width and byte-address width (Address is [NBITS-1:2])
//   DEPTH   - number of implemented words, 1..2**(NBITS-2)
//   LATENCY - wait cycles before the response, 0..15
//
// Ports:
//   clock      - rising-edge system clock
//   reset      - asynchronous active-low reset
//   MemRead    - read request, sampled in IDLE
//   MemWrite   - write request, sampled in IDLE
//   Address    - word address
//   WriteData  - store data
//   ReadData   - registered load data, valid while Ready is high
//   Ready      - one-cycle transaction-complete pulse
//   Busy       - high whenever the responder is not IDLE
//   Error      - one-cycle pulse: conflicting request or out-of-range address
//
// Optional feature (macro DMEM_ACCESS_COUNT_EN):
//   ReadCount / WriteCount - saturating 16-bit counts of completed in-range
//   reads and writes.
// ---------------------------------------------------------------------------
module data_memory_responder #(
    parameter int NBITS   = 8,
    parameter int DEPTH   = 2 ** (NBITS - 2),
    parameter int LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [NBITS-1:2]   Address,
    input  logic [NBITS-1:0]   WriteData,
    output logic [NBITS-1:0]   ReadData,
    output logic               Ready,
    output logic               Busy,
    output logic               Error
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]        ReadCount,
    output logic [15:0]        WriteCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0]       LAT_W   = LATENCY[3:0];
    // One bit wider than the address so a full-size DEPTH is representable.
    localparam logic [NBITS-2:0] DEPTH_W = DEPTH[NBITS-2:0];

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               is_write_q, is_write_d;
    logic [NBITS-1:2]   addr_q, addr_d;
    logic [NBITS-1:0]   wdata_q, wdata_d;
    logic [NBITS-1:0]   rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;

    logic [NBITS-1:0]   mem_q [DEPTH];

    logic [NBITS-1:2]   resp_addr_s;
    logic               resp_write_s;
    logic               in_range_s;
    logic [NBITS-1:0]   mem_rd_s;
    logic               mem_we_s;

    // With LATENCY=0 the response is prepared on the capture edge itself, so
    // the live inputs stand in for the not-yet-captured registers in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            resp_addr_s  = Address;
            resp_write_s = MemWrite;
        end else begin
            resp_addr_s  = addr_q;
            resp_write_s = is_write_q;
        end
        in_range_s = ({1'b0, resp_addr_s} < DEPTH_W);
        if (in_range_s) begin
            mem_rd_s = mem_q[resp_addr_s];
        end else begin
            mem_rd_s = {NBITS{1'b0}};
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        mem_we_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MemRead ^ MemWrite) begin
                    is_write_d = MemWrite;
                    addr_d     = Address;
                    wdata_d    = WriteData;
                    cnt_d      = LAT_W;
                    state_d    = (LAT_W != 4'd0) ? S_WAIT : S_RESP;
                end else if (MemRead & MemWrite) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                // The write commits on the edge that leaves RESP.
                mem_we_s = is_write_q & in_range_s;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response fields are loaded on the edge entering RESP so they line
        // up with the Ready cycle.
        if (state_d == S_RESP) begin
            ready_d = 1'b1;
            error_d = ~in_range_s;
            if (!resp_write_s) begin
                rdata_d = mem_rd_s;
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            ready_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= {(NBITS-2){1'b0}};
            wdata_q    <= {NBITS{1'b0}};
            rdata_q    <= {NBITS{1'b0}};
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    // Word storage, cleared on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {NBITS{1'b0}};
            end
        end else if (mem_we_s) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign ReadData = rdata_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign Error    = error_q;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rcnt_q, rcnt_d;
    logic [15:0] wcnt_q, wcnt_d;

    // Saturating access counters; only in-range RESP cycles count.
    always_comb begin
        rcnt_d = rcnt_q;
        wcnt_d = wcnt_q;
        if ((state_q == S_RESP) && in_range_s) begin
            if (is_write_q) begin
                wcnt_d = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
            end else begin
                rcnt_d = (rcnt_q == 16'hFFFF) ? rcnt_q : rcnt_q + 16'd1;
            end
        end else begin
            rcnt_d = rcnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rcnt_q <= 16'd0;
            wcnt_q <= 16'd0;
        end else begin
            rcnt_q <= rcnt_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign ReadCount  = rcnt_q;
    assign WriteCount = wcnt_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;

    // Instance A: LATENCY=2, DEPTH=48
    logic       a_rd = 1'b0, a_wr = 1'b0;
    logic [5:0] a_addr = 6'd0;
    logic [7:0] a_wdata = 8'd0;
    logic [7:0] a_rdata;
    logic       a_ready, a_busy, a_error;

    // Instance B: LATENCY=0, DEPTH=64
    logic       b_rd = 1'b0, b_wr = 1'b0;
    logic [5:0] b_addr = 6'd0;
    logic [7:0] b_wdata = 8'd0;
    logic [7:0] b_rdata;
    logic       b_ready, b_busy, b_error;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] a_rcnt, a_wcnt, b_rcnt, b_wcnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    data_memory_responder #(.NBITS(8), .DEPTH(48), .LATENCY(2)) dut_a (
        .clock(clock), .reset(reset),
        .MemRead(a_rd), .MemWrite(a_wr), .Address(a_addr), .WriteData(a_wdata),
        .ReadData(a_rdata), .Ready(a_ready), .Busy(a_busy), .Error(a_error)
`ifdef DMEM_ACCESS_COUNT_EN
        , .ReadCount(a_rcnt), .WriteCount(a_wcnt)
`endif
    );

    data_memory_responder #(.NBITS(8), .DEPTH(64), .LATENCY(0)) dut_b (
        .clock(clock), .reset(reset),
        .MemRead(b_rd), .MemWrite(b_wr), .Address(b_addr), .WriteData(b_wdata),
        .ReadData(b_rdata), .Ready(b_ready), .Busy(b_busy), .Error(b_error)
`ifdef DMEM_ACCESS_COUNT_EN
        , .ReadCount(b_rcnt), .WriteCount(b_wcnt)
`endif
    );

    // One transaction on instance A. Starts and ends at posedge+1.
    // lat = cycles from the request edge to the Ready cycle (0 = timed out).
    task automatic a_xact(input logic rd, input logic wr, input logic [5:0] addr,
                          input logic [7:0] data, output int lat, output logic err,
                          output logic [7:0] rdata, output logic busy1);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data;
        @(posedge clock); #1;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = 6'h3F; a_wdata = 8'h00;
        lat = 0; err = 1'b0; rdata = 8'h00; busy1 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (n == 1) busy1 = a_busy;
            if (a_ready) begin
                lat = n; err = a_error; rdata = a_rdata;
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({a_ready, a_busy, a_error, a_rdata} !== 11'd0) begin
            failures++;
            $display("FAIL reset_a: got rdy=%b busy=%b err=%b rdata=%h, want 0", a_ready, a_busy, a_error, a_rdata);
        end
        checks++;
        if ({b_ready, b_busy, b_error, b_rdata} !== 11'd0) begin
            failures++;
            $display("FAIL reset_b: got rdy=%b busy=%b err=%b rdata=%h, want 0", b_ready, b_busy, b_error, b_rdata);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_latency();
        int lat; logic err; logic [7:0] rd; logic b1;
        a_xact(1'b0, 1'b1, 6'd5, 8'hA5, lat, err, rd, b1);
        checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d want 3", lat); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_error: got %b want 0", err); end
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL wait_busy: got %b want 1", b1); end
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL wr_keeps_rdata: got %h want 00", rd); end
        a_xact(1'b1, 1'b0, 6'd5, 8'h00, lat, err, rd, b1);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d want 3", lat); end
        checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL rd_data: got %h want a5", rd); end
        @(negedge clock);
        checks++; if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
            failures++; $display("FAIL ready_one_cycle: got rdy=%b busy=%b want 0 0", a_ready, a_busy);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int j = 0; j < 8; j++) begin
            b_wr = (j % 2 == 0); b_rd = (j % 2 == 1);
            b_addr = 6'(j / 2); b_wdata = 8'h10 + 8'(j / 2);
            exp = 8'h10 + 8'(j / 2);
            @(negedge clock);
            checks++; if (b_ready !== 1'b0 || b_busy !== 1'b0) begin
                failures++; $display("FAIL b2b_idle[%0d]: got rdy=%b busy=%b want 0 0", j, b_ready, b_busy);
            end
            @(posedge clock); #1;
            b_wr = 1'b0; b_rd = 1'b0; b_addr = 6'h3F; b_wdata = 8'h00;
            @(negedge clock);
            checks++; if (b_ready !== 1'b1 || b_busy !== 1'b1 || b_error !== 1'b0) begin
                failures++; $display("FAIL b2b_resp[%0d]: got rdy=%b busy=%b err=%b want 1 1 0", j, b_ready, b_busy, b_error);
            end
            if (j % 2 == 1) begin
                checks++; if (b_rdata !== exp) begin
                    failures++; $display("FAIL b2b_rdata[%0d]: got %h want %h", j, b_rdata, exp);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_conflict();
        int lat; logic err; logic [7:0] rd; logic b1;
        a_rd = 1'b1; a_wr = 1'b1; a_addr = 6'd5; a_wdata = 8'h00;
        @(posedge clock); #1;
        a_rd = 1'b0; a_wr = 1'b0;
        @(negedge clock);
        checks++; if (a_error !== 1'b1 || a_ready !== 1'b0 || a_busy !== 1'b0) begin
            failures++; $display("FAIL conflict_pulse: got err=%b rdy=%b busy=%b want 1 0 0", a_error, a_ready, a_busy);
        end
        @(negedge clock);
        checks++; if (a_error !== 1'b0 || a_ready !== 1'b0 || a_rdata !== 8'hA5) begin
            failures++; $display("FAIL conflict_after: got err=%b rdy=%b rdata=%h want 0 0 a5", a_error, a_ready, a_rdata);
        end
        @(posedge clock); #1;
        a_xact(1'b1, 1'b0, 6'd5, 8'h00, lat, err, rd, b1);
        checks++; if (rd !== 8'hA5 || lat !== 3) begin
            failures++; $display("FAIL conflict_mem: got rdata=%h lat=%0d want a5 3", rd, lat);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic err; logic [7:0] rd; logic b1;
        a_xact(1'b0, 1'b1, 6'd47, 8'h47, lat, err, rd, b1);
        checks++; if (err !== 1'b0 || lat !== 3) begin
            failures++; $display("FAIL wr47: got err=%b lat=%0d want 0 3", err, lat);
        end
        a_xact(1'b1, 1'b0, 6'd50, 8'h00, lat, err, rd, b1);
        checks++; if (err !== 1'b1 || lat !== 3 || rd !== 8'h00) begin
            failures++; $display("FAIL oor_read: got err=%b lat=%0d rdata=%h want 1 3 00", err, lat, rd);
        end
        a_xact(1'b0, 1'b1, 6'd50, 8'hFF, lat, err, rd, b1);
        checks++; if (err !== 1'b1 || lat !== 3) begin
            failures++; $display("FAIL oor_write: got err=%b lat=%0d want 1 3", err, lat);
        end
        a_xact(1'b1, 1'b0, 6'd2, 8'h00, lat, err, rd, b1);
        checks++; if (rd !== 8'h00 || err !== 1'b0) begin
            failures++; $display("FAIL no_wrap: got rdata=%h err=%b want 00 0", rd, err);
        end
        a_xact(1'b1, 1'b0, 6'd47, 8'h00, lat, err, rd, b1);
        checks++; if (rd !== 8'h47 || err !== 1'b0) begin
            failures++; $display("FAIL rd47: got rdata=%h err=%b want 47 0", rd, err);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic err; logic [7:0] rd; logic b1; logic seen;
        a_wr = 1'b1; a_addr = 6'd9; a_wdata = 8'h3C;
        @(posedge clock); #1;
        a_wr = 1'b0;
        @(negedge clock);
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL abort_wait_busy: got %b want 1", a_busy); end
        reset = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_rdata !== 8'h00) begin
            failures++; $display("FAIL abort_reset: got busy=%b rdy=%b rdata=%h want 0 0 00", a_busy, a_ready, a_rdata);
        end
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin @(negedge clock); seen |= a_ready; end
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin @(negedge clock); seen |= a_ready; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_ready: got %b want 0", seen); end
        @(posedge clock); #1;
        a_xact(1'b1, 1'b0, 6'd9, 8'h00, lat, err, rd, b1);
        checks++; if (rd !== 8'h00 || lat !== 3) begin
            failures++; $display("FAIL abort_mem: got rdata=%h lat=%0d want 00 3", rd, lat);
        end
    endtask

`ifdef DMEM_ACCESS_COUNT_EN
    task automatic test_counts();
        int lat; logic err; logic [7:0] rd; logic b1;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        a_xact(1'b1, 1'b0, 6'd0, 8'h00, lat, err, rd, b1);
        a_xact(1'b1, 1'b0, 6'd1, 8'h00, lat, err, rd, b1);
        a_xact(1'b1, 1'b0, 6'd2, 8'h00, lat, err, rd, b1);
        a_xact(1'b0, 1'b1, 6'd3, 8'h33, lat, err, rd, b1);
        a_xact(1'b0, 1'b1, 6'd4, 8'h44, lat, err, rd, b1);
        a_xact(1'b0, 1'b1, 6'd60, 8'hEE, lat, err, rd, b1);
        @(negedge clock);
        checks++; if (a_rcnt !== 16'd3) begin failures++; $display("FAIL read_count: got %0d want 3", a_rcnt); end
        checks++; if (a_wcnt !== 16'd2) begin failures++; $display("FAIL write_count: got %0d want 2", a_wcnt); end
        @(posedge clock); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_conflict();
        test_out_of_range();
        test_reset_abort();
`ifdef DMEM_ACCESS_COUNT_EN
        test_counts();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
